// File: rtl/uno_pkg.sv
// Shared card-game types and constants: card encoding, draw command codes and hand FSM states.
package uno_pkg;

    typedef struct packed {
        logic [1:0] color;
        logic [3:0] value;
    } card_t;

    localparam logic [1:0] COLOR_RED    = 2'd0;
    localparam logic [1:0] COLOR_YELLOW = 2'd1;
    localparam logic [1:0] COLOR_GREEN  = 2'd2;
    localparam logic [1:0] COLOR_BLUE   = 2'd3;

    localparam logic [3:0] VAL_SKIP  = 4'd10;
    localparam logic [3:0] VAL_REV   = 4'd11;
    localparam logic [3:0] VAL_DRAW2 = 4'd12;
    localparam logic [3:0] VAL_WILD  = 4'd13;
    localparam logic [3:0] VAL_WILD4 = 4'd14;

    localparam logic [2:0] DRAW_NONE = 3'b000;
    localparam logic [2:0] DRAW_ONE  = 3'b001;
    localparam logic [2:0] DRAW_TWO  = 3'b010;
    localparam logic [2:0] DRAW_FOUR = 3'b100;

    localparam logic [2:0] INIT_DEAL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } hand_state_e;

endpackage

// File: rtl/uno_legal_check.sv
// Combinational play-legality rule: wilds always play, otherwise colour or value must match.
module uno_legal_check
    import uno_pkg::*;
(
    input  card_t      i_card,
    input  logic [3:0] i_top_value,
    input  logic [1:0] i_cur_color,
    output logic       o_legal
);

    assign o_legal = (i_card.value == VAL_WILD)  ||
                     (i_card.value == VAL_WILD4) ||
                     (i_card.color == i_cur_color) ||
                     (i_card.value == i_top_value);

endmodule

// File: rtl/player_hand.sv
// One player's hand: requests cards from the deck, stores dealt cards, tracks a cursor
// and removes the selected card on a legal play.
module player_hand
    import uno_pkg::*;
#(
    parameter int MAX_CARDS = 32,
    parameter int IDX_W     = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_init,
    input  logic [2:0]       i_req,
    input  logic             i_deck_done,
    input  logic             i_drawn,
    input  logic [5:0]       i_card,
    output logic [2:0]       o_draw,
    input  logic             i_sel_next,
    input  logic             i_sel_prev,
    input  logic             i_play,
    input  logic [3:0]       i_top_value,
    input  logic [1:0]       i_cur_color,
    output logic [5:0]       o_sel_card,
    output logic [IDX_W-1:0] o_count,
    output logic             o_play_valid,
    output logic [5:0]       o_played_card,
    output logic             o_illegal,
    output logic             o_overflow,
    output logic             o_busy,
    output logic             o_empty
);

    localparam int               SLOT_W  = $clog2(MAX_CARDS);
    localparam logic [IDX_W-1:0] MAX_CNT = IDX_W'(MAX_CARDS);

    hand_state_e      r_state, w_state_nxt;
    logic [IDX_W-1:0] r_count, w_count_nxt;
    logic [IDX_W-1:0] r_cursor, w_cursor_nxt, w_cursor_moved, w_last_idx;
    logic [2:0]       r_remaining, w_remaining_nxt;
    logic             r_is_init, w_is_init_nxt;
    logic [2:0]       r_req_code, w_req_code_nxt;
    logic [2:0]       r_draw, w_draw_nxt;
    logic             r_play_valid, w_play_valid_nxt;
    logic             r_illegal, w_illegal_nxt;
    logic             r_overflow, w_overflow_nxt;
    card_t            r_played_card, w_played_card_nxt;
    card_t            r_slots [MAX_CARDS];

    logic             w_wr_en;
    logic [SLOT_W-1:0] w_wr_idx;
    card_t            w_wr_data;
    card_t            w_cur_card;
    card_t            w_last_card;
    logic             w_legal;
    logic             w_req_valid;

    assign w_last_idx  = r_count - IDX_W'(1);
    assign w_cur_card  = r_slots[r_cursor[SLOT_W-1:0]];
    assign w_last_card = r_slots[w_last_idx[SLOT_W-1:0]];
    assign w_req_valid = (i_req == DRAW_ONE) || (i_req == DRAW_TWO) || (i_req == DRAW_FOUR);

    uno_legal_check u_legal (
        .i_card      (w_cur_card),
        .i_top_value (i_top_value),
        .i_cur_color (i_cur_color),
        .o_legal     (w_legal)
    );

    // Cursor moves wrap within the occupied slots; opposite requests cancel out.
    always_comb begin
        w_cursor_moved = r_cursor;
        if (r_count == '0) begin
            w_cursor_moved = '0;
        end else if (i_sel_next && !i_sel_prev) begin
            w_cursor_moved = (r_cursor == w_last_idx) ? '0 : r_cursor + IDX_W'(1);
        end else if (i_sel_prev && !i_sel_next) begin
            w_cursor_moved = (r_cursor == '0) ? w_last_idx : r_cursor - IDX_W'(1);
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_count_nxt       = r_count;
        w_cursor_nxt      = w_cursor_moved;
        w_remaining_nxt   = r_remaining;
        w_is_init_nxt     = r_is_init;
        w_req_code_nxt    = r_req_code;
        w_draw_nxt        = DRAW_NONE;
        w_play_valid_nxt  = 1'b0;
        w_illegal_nxt     = 1'b0;
        w_overflow_nxt    = 1'b0;
        w_played_card_nxt = r_played_card;
        w_wr_en           = 1'b0;
        w_wr_idx          = r_count[SLOT_W-1:0];
        w_wr_data         = card_t'(i_card);

        case (r_state)
            S_IDLE: begin
                if (i_init) begin
                    w_count_nxt     = '0;
                    w_cursor_nxt    = '0;
                    w_remaining_nxt = INIT_DEAL;
                    w_is_init_nxt   = 1'b1;
                    w_req_code_nxt  = DRAW_ONE;
                    w_state_nxt     = S_REQ;
                end else if (w_req_valid) begin
                    w_remaining_nxt = (i_req == DRAW_FOUR) ? 3'd4 :
                                      (i_req == DRAW_TWO)  ? 3'd2 : 3'd1;
                    w_is_init_nxt   = 1'b0;
                    w_req_code_nxt  = i_req;
                    w_state_nxt     = S_REQ;
                end else if (i_play) begin
                    w_cursor_nxt = r_cursor;
                    if ((r_count != '0) && w_legal) begin
                        // Fill the hole with the last card so the slots stay packed.
                        w_played_card_nxt = w_cur_card;
                        w_play_valid_nxt  = 1'b1;
                        w_wr_en           = 1'b1;
                        w_wr_idx          = r_cursor[SLOT_W-1:0];
                        w_wr_data         = w_last_card;
                        w_count_nxt       = w_last_idx;
                        if (r_cursor >= w_last_idx) begin
                            w_cursor_nxt = '0;
                        end
                    end else begin
                        w_illegal_nxt = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (i_deck_done) begin
                    w_draw_nxt  = r_req_code;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_drawn) begin
                    if (r_count < MAX_CNT) begin
                        w_wr_en     = 1'b1;
                        w_count_nxt = r_count + IDX_W'(1);
                    end else begin
                        w_overflow_nxt = 1'b1;
                    end
                    w_remaining_nxt = r_remaining - 3'd1;
                    if (r_remaining == 3'd1) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_is_init) begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_count       <= '0;
            r_cursor      <= '0;
            r_remaining   <= '0;
            r_is_init     <= 1'b0;
            r_req_code    <= DRAW_NONE;
            r_draw        <= DRAW_NONE;
            r_play_valid  <= 1'b0;
            r_illegal     <= 1'b0;
            r_overflow    <= 1'b0;
            r_played_card <= '0;
            for (int i = 0; i < MAX_CARDS; i++) begin
                r_slots[i] <= '0;
            end
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_cursor      <= w_cursor_nxt;
            r_remaining   <= w_remaining_nxt;
            r_is_init     <= w_is_init_nxt;
            r_req_code    <= w_req_code_nxt;
            r_draw        <= w_draw_nxt;
            r_play_valid  <= w_play_valid_nxt;
            r_illegal     <= w_illegal_nxt;
            r_overflow    <= w_overflow_nxt;
            r_played_card <= w_played_card_nxt;
            if (w_wr_en) begin
                r_slots[w_wr_idx] <= w_wr_data;
            end
        end
    end

    assign o_draw        = r_draw;
    assign o_sel_card    = (r_count == '0) ? 6'd0 : w_cur_card;
    assign o_count       = r_count;
    assign o_play_valid  = r_play_valid;
    assign o_played_card = r_played_card;
    assign o_illegal     = r_illegal;
    assign o_overflow    = r_overflow;
    assign o_busy        = (r_state != S_IDLE);
    assign o_empty       = (r_count == '0);

endmodule

// File: tb/tb_player_hand.sv
// Bench for player_hand: a queue-based hand model plus an in-line deck model drive directed and random scenarios.
module tb_player_hand;

    logic       clk = 1'b0;
    logic       rst, init, deck_done, drawn, sel_next, sel_prev, play;
    logic [2:0] req;
    logic [5:0] card;
    logic [3:0] top_value;
    logic [1:0] cur_color;
    logic [2:0] o_draw;
    logic [5:0] o_sel_card, o_played_card;
    logic [5:0] o_count;
    logic       o_play_valid, o_illegal, o_overflow, o_busy, o_empty;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [5:0] hand[$];
    logic [5:0] pending[$];
    int         cur = 0;

    always #5 clk = ~clk;

    player_hand #(.MAX_CARDS(32), .IDX_W(6)) dut (
        .i_clk(clk), .i_rst(rst), .i_init(init), .i_req(req), .i_deck_done(deck_done),
        .i_drawn(drawn), .i_card(card), .o_draw(o_draw), .i_sel_next(sel_next),
        .i_sel_prev(sel_prev), .i_play(play), .i_top_value(top_value), .i_cur_color(cur_color),
        .o_sel_card(o_sel_card), .o_count(o_count), .o_play_valid(o_play_valid),
        .o_played_card(o_played_card), .o_illegal(o_illegal), .o_overflow(o_overflow),
        .o_busy(o_busy), .o_empty(o_empty)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_legal(logic [5:0] c, logic [3:0] top, logic [1:0] col);
        int v = int'(c) % 16;
        int k = int'(c) / 16;
        return (v == 13) || (v == 14) || (k == int'(col)) || (v == int'(top));
    endfunction

    function automatic logic [5:0] exp_sel();
        return (hand.size() == 0) ? 6'd0 : hand[cur];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        hand.delete();
        pending.delete();
        cur = 0;
    endtask

    // Full draw transaction with a cooperative deck: one request for a draw, seven for a deal.
    task automatic deal(input logic [2:0] code, input bit is_init);
        int         n_req, per_req, waited;
        logic [2:0] exp_code;
        logic [5:0] c;
        bit         exp_ovf;
        n_req    = is_init ? 7 : 1;
        per_req  = is_init ? 1 : ((code == 3'b100) ? 4 : (code == 3'b010) ? 2 : 1);
        exp_code = is_init ? 3'b001 : code;
        if (is_init) init = 1'b1; else req = code;
        tick();
        init = 1'b0;
        req  = 3'b000;
        if (is_init) begin
            hand.delete();
            cur = 0;
        end
        for (int r = 0; r < n_req; r++) begin
            waited = 0;
            while (o_draw == 3'b000 && waited < 20) begin
                tick();
                waited++;
            end
            n_checks++;
            if (o_draw !== exp_code) begin
                n_fail++;
                $display("[TB] FAIL draw_cmd request %0d: got %b expected %b", r, o_draw, exp_code);
                deck_done = 1'b1;
                return;
            end
            deck_done = 1'b0;
            tick();
            n_checks++;
            if (o_draw !== 3'b000) begin
                n_fail++;
                $display("[TB] FAIL draw_pulse_width: got %b expected 000", o_draw);
            end
            repeat ($urandom_range(0, 2)) tick();
            for (int k = 0; k < per_req; k++) begin
                c = (pending.size() > 0) ? pending.pop_front() : 6'($urandom_range(0, 63));
                exp_ovf = (hand.size() >= 32);
                if (!exp_ovf) hand.push_back(c);
                drawn = 1'b1;
                card  = c;
                tick();
                drawn = 1'b0;
                n_checks++;
                if (o_overflow !== exp_ovf) begin
                    n_fail++;
                    $display("[TB] FAIL overflow_pulse card %0d: got %b expected %b", k, o_overflow, exp_ovf);
                end
                repeat ($urandom_range(0, 1)) tick();
            end
            deck_done = 1'b1;
        end
        n_checks++;
        if (o_count !== 6'(hand.size()) || o_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL deal_end: count %0d busy %b expected count %0d busy 0", o_count, o_busy, hand.size());
        end
    endtask

    task automatic move(input bit nx, input bit pv);
        int n = hand.size();
        sel_next = nx;
        sel_prev = pv;
        tick();
        sel_next = 1'b0;
        sel_prev = 1'b0;
        if (n == 0) cur = 0;
        else if (nx && !pv) cur = (cur + 1) % n;
        else if (pv && !nx) cur = (cur + n - 1) % n;
        n_checks++;
        if (o_sel_card !== exp_sel()) begin
            n_fail++;
            $display("[TB] FAIL cursor_move next=%b prev=%b: sel %h expected %h", nx, pv, o_sel_card, exp_sel());
        end
    endtask

    task automatic do_play(input bit with_next, input logic [3:0] top, input logic [1:0] col);
        bit         legal;
        logic [5:0] exp_card;
        exp_card  = 6'd0;
        top_value = top;
        cur_color = col;
        play      = 1'b1;
        sel_next  = with_next;
        tick();
        play     = 1'b0;
        sel_next = 1'b0;
        legal = (hand.size() > 0) && model_legal(hand[cur], top, col);
        if (legal) begin
            exp_card  = hand[cur];
            hand[cur] = hand[hand.size() - 1];
            void'(hand.pop_back());
            if (cur >= hand.size()) cur = 0;
        end
        n_checks++;
        if (o_play_valid !== legal || o_illegal !== !legal) begin
            n_fail++;
            $display("[TB] FAIL play_result: valid %b illegal %b expected valid %b", o_play_valid, o_illegal, legal);
        end
        if (legal) begin
            n_checks++;
            if (o_played_card !== exp_card) begin
                n_fail++;
                $display("[TB] FAIL played_card: got %h expected %h", o_played_card, exp_card);
            end
        end
        n_checks++;
        if (o_count !== 6'(hand.size()) || o_sel_card !== exp_sel()) begin
            n_fail++;
            $display("[TB] FAIL play_hand: count %0d sel %h expected count %0d sel %h",
                     o_count, o_sel_card, hand.size(), exp_sel());
        end
        tick();
        n_checks++;
        if (o_play_valid !== 1'b0 || o_illegal !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL play_pulse_width: valid %b illegal %b expected 0 0", o_play_valid, o_illegal);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (o_count !== 6'd0 || o_empty !== 1'b1 || o_busy !== 1'b0 || o_draw !== 3'b000 ||
            o_sel_card !== 6'd0 || o_played_card !== 6'd0 || o_play_valid !== 1'b0 ||
            o_illegal !== 1'b0 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: count %0d empty %b busy %b draw %b sel %h played %h",
                     o_count, o_empty, o_busy, o_draw, o_sel_card, o_played_card);
        end
    endtask

    task automatic test_init_deal();
        do_reset();
        for (int i = 1; i <= 7; i++) pending.push_back(6'(i));
        deal(3'b000, 1'b1);
        n_checks++;
        if (o_count !== 6'd7 || o_sel_card !== 6'h01) begin
            n_fail++;
            $display("[TB] FAIL init_deal: count %0d sel %h expected 7 01", o_count, o_sel_card);
        end
        for (int i = 0; i < 6; i++) move(1'b1, 1'b0);
    endtask

    task automatic test_legal_play();
        do_reset();
        pending.push_back(6'h05);
        pending.push_back(6'h17);
        deal(3'b010, 1'b0);
        move(1'b1, 1'b0);
        do_play(1'b0, 4'd7, 2'd0);
    endtask

    task automatic test_illegal_then_wild();
        do_reset();
        pending.push_back(6'h23);
        deal(3'b001, 1'b0);
        do_play(1'b0, 4'd9, 2'd3);
        pending.push_back(6'h0D);
        deal(3'b001, 1'b0);
        move(1'b1, 1'b0);
        do_play(1'b0, 4'd9, 2'd3);
    endtask

    task automatic test_overflow();
        do_reset();
        deal(3'b000, 1'b1);
        for (int i = 0; i < 6; i++) deal(3'b100, 1'b0);
        n_checks++;
        if (o_count !== 6'd31) begin
            n_fail++;
            $display("[TB] FAIL overflow_setup: count %0d expected 31", o_count);
        end
        deal(3'b100, 1'b0);
        n_checks++;
        if (o_count !== 6'd32 || o_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL overflow_final: count %0d busy %b expected 32 0", o_count, o_busy);
        end
    endtask

    task automatic test_cursor();
        do_reset();
        pending.push_back(6'h11);
        pending.push_back(6'h22);
        pending.push_back(6'h33);
        deal(3'b010, 1'b0);
        deal(3'b001, 1'b0);
        move(1'b0, 1'b1);
        move(1'b1, 1'b0);
        move(1'b0, 1'b1);
        move(1'b1, 1'b1);
        do_play(1'b1, 4'd0, 2'd3);
    endtask

    task automatic test_reset_mid_draw();
        int waited;
        do_reset();
        req = 3'b100;
        tick();
        req = 3'b000;
        waited = 0;
        while (o_draw == 3'b000 && waited < 20) begin
            tick();
            waited++;
        end
        deck_done = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            drawn = 1'b1;
            card  = 6'($urandom_range(0, 63));
            tick();
            drawn = 1'b0;
        end
        play      = 1'b1;
        top_value = card[3:0];
        tick();
        play = 1'b0;
        n_checks++;
        if (o_count !== 6'd2 || o_busy !== 1'b1 || o_illegal !== 1'b0 || o_play_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL mid_draw: count %0d busy %b illegal %b valid %b expected 2 1 0 0",
                     o_count, o_busy, o_illegal, o_play_valid);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (o_count !== 6'd0 || o_draw !== 3'b000 || o_busy !== 1'b0 || o_empty !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_draw: count %0d draw %b busy %b expected 0 000 0",
                     o_count, o_draw, o_busy);
        end
        drawn = 1'b1;
        card  = 6'h2A;
        tick();
        drawn = 1'b0;
        deck_done = 1'b1;
        n_checks++;
        if (o_count !== 6'd0 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stray_drawn: count %0d overflow %b expected 0 0", o_count, o_overflow);
        end
        hand.delete();
        cur = 0;
    endtask

    task automatic test_random();
        logic [2:0] codes [3];
        int         op;
        codes[0] = 3'b001;
        codes[1] = 3'b010;
        codes[2] = 3'b100;
        do_reset();
        deal(3'b000, 1'b1);
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 9);
            if (op < 2) begin
                deal(codes[$urandom_range(0, 2)], 1'b0);
            end else if (op < 6) begin
                move(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else if (hand.size() > 0 && $urandom_range(0, 1) == 1) begin
                do_play(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), hand[cur][5:4]);
            end else begin
                do_play(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            end
        end
    endtask

    initial begin
        rst = 1'b1; init = 1'b0; req = 3'b000; deck_done = 1'b1; drawn = 1'b0; card = 6'd0;
        sel_next = 1'b0; sel_prev = 1'b0; play = 1'b0; top_value = 4'd0; cur_color = 2'd0;
        test_reset();
        test_init_deal();
        test_legal_play();
        test_illegal_then_wild();
        test_overflow();
        test_cursor();
        test_reset_mid_draw();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
